diff_fm_pingpong_bank: RTL
==========================

# diff_fm_pingpong_bank

Parametrised ping-pong feature-map/guard buffer bank for the diff core. It provides COLS columns, each with two identical banks. At any time one bank belongs to the core (PE read / write-back) and the other to the host (load/save). The core controller swaps bank ownership between layers with a valid/ready handshake. The block tracks per-column host fill levels and counts swaps, and can optionally zero-clear the bank handed back to the host.

## Interface
- COLS, 4, number of PE columns (independent bank pairs)
- DATA_W, 72, word width (9×8b fm or 12×6b guard)
- DEPTH, 512, words per bank; power of two, ≥ 4
- ADDR_W, $clog2(DEPTH), derived; not overridden
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- swap_valid  in  1  controller requests ownership swap
- swap_ready  out  1  swap may be accepted this cycle
- core_bank  out  1  index of bank currently owned by core
- swap_cnt  out  8  accepted swaps, wraps modulo 256
- core_rd_addr  in  COLS×ADDR_W  core read address per column
- core_rd_dout  out  COLS×DATA_W  core read data, 1-cycle latency
- core_wr_addr  in  COLS×ADDR_W  write-back address
- core_wr_din  in  COLS×DATA_W  write-back data
- core_wr_en  in  COLS  write-back strobe
- host_rd_addr  in  COLS×ADDR_W  save-path read address
- host_rd_dout  out  COLS×DATA_W  save-path read data, 1-cycle latency
- host_wr_addr  in  COLS×ADDR_W  load-path address
- host_wr_din  in  COLS×DATA_W  load-path data
- host_wr_en  in  COLS  load-path strobe
- host_ready  out  1  host writes accepted
- host_fill  out  COLS×(ADDR_W+1)  accepted host writes since last swap, saturating at DEPTH

## Operation
- Core side accesses bank core_bank; host side accesses bank ~core_bank.
- The two sides never collide.
- Same-side read and write to the same address in one cycle is read-first: the read returns the old word.
- Swap handshake:
  - Fires at a rising edge where swap_valid && swap_ready.
  - Next cycle: core_bank toggles, swap_cnt increments (255→0), every host_fill is cleared to 0.
  - swap_valid may stay high across multiple accepted swaps; each accepted cycle is one swap.
- Writes presented in the swap cycle land in the pre-swap mapping.
- host_fill[c] increments on each accepted host_wr_en[c], regardless of address, and holds at DEPTH.
- A host write in the swap cycle is not counted; the clear takes priority.
- Memory contents are not reset.
- States: RUN, plus CLEAR when the macro is enabled.
- Without the macro the block is permanently in RUN, and swap_ready = host_ready = 1.

## Timing
- Read latency is exactly 1 cycle on both sides.
- The output mux uses the bank select registered in the issue cycle, so a read issued in the swap cycle returns pre-swap-bank data.
- Reset values:
  - core_bank=0, swap_cnt=0, host_fill=0
  - core_rd_dout=0, host_rd_dout=0
  - swap_ready=1, host_ready=1
  - state=RUN
- swap_ready depends only on state, never combinationally on swap_valid or the write enables.
- Write-to-read on the same side and address: data is visible to a read issued the following cycle.
- Reset asserted mid-operation, including mid-CLEAR: all registers return to reset values immediately. Any clear in progress is abandoned and partially cleared words remain as written.

## Configuration
- Macro: DIFF_PP_CLEAR_ON_SWAP_EN.
- Defined:
  - After each accepted swap the block enters CLEAR for exactly DEPTH cycles.
  - It writes zero to addresses 0..DEPTH-1 of the new host-side bank in all columns, ascending from 0, one address per cycle.
  - During CLEAR: host_ready=0 and swap_ready=0. host_wr_en is ignored and not counted in host_fill. host reads are permitted and return the current (partially cleared) contents. The core side is unaffected.
  - Returns to RUN after address DEPTH-1 is written; host_ready and swap_ready are 1 in the following cycle.
- Undefined:
  - No CLEAR state and no clear address counter.
  - host_ready and swap_ready are constant 1.

## Test plan
All tests use COLS=2, DATA_W=72, DEPTH=16.
- Reset with no stimulus → core_bank=0, swap_cnt=0, host_fill={0,0}, both douts 0, swap_ready=1, host_ready=1.
- Host write col1 addr 3 = 0xAB, then swap, then core read col1 addr 3 → core_rd_dout[1]=0xAB one cycle after the read; host_fill[1] is 1 before the swap and 0 after; core_bank=1.
- Core write col0 addr 5 = 0x55 (bank 0), host write col0 addr 5 = 0x77 (bank 1); core read col0 addr 5 issued in the swap cycle → returns 0x55; the same read repeated after the swap → returns 0x77.
- 20 host writes to col0 with no swap → host_fill[0] reaches 16 and holds; 256 consecutive swaps → swap_cnt returns to 0, core_bank back to 0.
- Macro defined; host writes 0xFF to all 16 addresses of bank 1, core_bank=1, then swap → host_ready and swap_ready are low for 16 cycles, a host write during CLEAR leaves host_fill at 0, and host reads of bank 0 (new host side) afterwards return 0 at every address. Macro undefined → host_ready never drops.
- Macro defined; assert rst_n low at CLEAR cycle 6 → core_bank=0, state RUN, host_ready=1 next cycle, addresses 0..5 of the cleared bank read 0 and the rest keep their old values.

Source files
------------

// File: rtl/diff_fm_pingpong_bank.sv
// Ping-pong feature-map/guard bank: COLS bank pairs with core/host ownership swapped by handshake.
// Optional zero-clear of the returned host bank after each swap: define DIFF_PP_CLEAR_ON_SWAP_EN.
module diff_fm_pingpong_bank #(
  parameter int unsigned COLS   = 4,
  parameter int unsigned DATA_W = 72,
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       swap_valid,
  output logic                       swap_ready,
  output logic                       core_bank,
  output logic [7:0]                 swap_cnt,
  input  logic [COLS*ADDR_W-1:0]     core_rd_addr,
  output logic [COLS*DATA_W-1:0]     core_rd_dout,
  input  logic [COLS*ADDR_W-1:0]     core_wr_addr,
  input  logic [COLS*DATA_W-1:0]     core_wr_din,
  input  logic [COLS-1:0]            core_wr_en,
  input  logic [COLS*ADDR_W-1:0]     host_rd_addr,
  output logic [COLS*DATA_W-1:0]     host_rd_dout,
  input  logic [COLS*ADDR_W-1:0]     host_wr_addr,
  input  logic [COLS*DATA_W-1:0]     host_wr_din,
  input  logic [COLS-1:0]            host_wr_en,
  output logic                       host_ready,
  output logic [COLS*(ADDR_W+1)-1:0] host_fill
);

  localparam int unsigned FILL_W = ADDR_W + 1;
  localparam int unsigned CNT_W  = 8;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

  logic             core_bank_q;
  logic [CNT_W-1:0] swap_cnt_q;
  logic             swap_fire_c;

  assign swap_fire_c = swap_valid & swap_ready;
  assign core_bank   = core_bank_q;
  assign swap_cnt    = swap_cnt_q;

  // Bank ownership and swap counter advance on each accepted swap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_bank_q <= 1'b0;
      swap_cnt_q  <= '0;
    end else if (swap_fire_c) begin
      core_bank_q <= ~core_bank_q;
      swap_cnt_q  <= swap_cnt_q + CNT_W'(1);
    end
  end

`ifdef DIFF_PP_CLEAR_ON_SWAP_EN
  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [0:0]        state_q;
  logic [0:0]        state_d;
  logic [ADDR_W-1:0] clr_addr_q;
  logic [ADDR_W-1:0] clr_addr_d;
  logic              ready_q;
  logic              clearing_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      clr_addr_q <= '0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      ready_q    <= (state_d == RUN);
    end
  end

  // CLEAR walks every address of the new host bank once, then hands back to RUN
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      RUN: begin
        if (swap_fire_c) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end
      end
      CLEAR: begin
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d    = RUN;
        clr_addr_d = '0;
      end
    endcase
  end

  assign clearing_c = (state_q == CLEAR);
  assign swap_ready = ready_q;
  assign host_ready = ready_q;
`else
  assign swap_ready = 1'b1;
  assign host_ready = 1'b1;
`endif

  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic [DATA_W-1:0] mem0 [DEPTH];
    logic [DATA_W-1:0] mem1 [DEPTH];

    logic [ADDR_W-1:0] c_ra;
    logic [ADDR_W-1:0] c_wa;
    logic [DATA_W-1:0] c_wd;
    logic [ADDR_W-1:0] h_ra;
    logic              h_we_c;
    logic              h_acc_c;
    logic [ADDR_W-1:0] h_wa_c;
    logic [DATA_W-1:0] h_wd_c;

    logic              b0_we_c;
    logic [ADDR_W-1:0] b0_wa_c;
    logic [DATA_W-1:0] b0_wd_c;
    logic              b1_we_c;
    logic [ADDR_W-1:0] b1_wa_c;
    logic [DATA_W-1:0] b1_wd_c;

    logic [DATA_W-1:0] core_dout_q;
    logic [DATA_W-1:0] host_dout_q;
    logic [FILL_W-1:0] fill_q;

    assign c_ra = core_rd_addr[c*ADDR_W +: ADDR_W];
    assign c_wa = core_wr_addr[c*ADDR_W +: ADDR_W];
    assign c_wd = core_wr_din[c*DATA_W +: DATA_W];
    assign h_ra = host_rd_addr[c*ADDR_W +: ADDR_W];

`ifdef DIFF_PP_CLEAR_ON_SWAP_EN
    // The clear sequencer owns the host write port while clearing
    assign h_we_c  = clearing_c | host_wr_en[c];
    assign h_acc_c = host_wr_en[c] & ~clearing_c;
    assign h_wa_c  = clearing_c ? clr_addr_q : host_wr_addr[c*ADDR_W +: ADDR_W];
    assign h_wd_c  = clearing_c ? '0 : host_wr_din[c*DATA_W +: DATA_W];
`else
    assign h_we_c  = host_wr_en[c];
    assign h_acc_c = host_wr_en[c];
    assign h_wa_c  = host_wr_addr[c*ADDR_W +: ADDR_W];
    assign h_wd_c  = host_wr_din[c*DATA_W +: DATA_W];
`endif

    // Route each side's write port to the bank it currently owns
    assign b0_we_c = core_bank_q ? h_we_c : core_wr_en[c];
    assign b0_wa_c = core_bank_q ? h_wa_c : c_wa;
    assign b0_wd_c = core_bank_q ? h_wd_c : c_wd;
    assign b1_we_c = core_bank_q ? core_wr_en[c] : h_we_c;
    assign b1_wa_c = core_bank_q ? c_wa : h_wa_c;
    assign b1_wd_c = core_bank_q ? c_wd : h_wd_c;

    always_ff @(posedge clk) begin
      if (b0_we_c) begin
        mem0[b0_wa_c] <= b0_wd_c;
      end
      if (b1_we_c) begin
        mem1[b1_wa_c] <= b1_wd_c;
      end
    end

    // Read-first registered reads; bank select is the one in force at issue
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        core_dout_q <= '0;
        host_dout_q <= '0;
      end else begin
        core_dout_q <= core_bank_q ? mem1[c_ra] : mem0[c_ra];
        host_dout_q <= core_bank_q ? mem0[h_ra] : mem1[h_ra];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        fill_q <= '0;
      end else if (swap_fire_c) begin
        fill_q <= '0;
      end else if (h_acc_c && (fill_q != FILL_MAX)) begin
        fill_q <= fill_q + FILL_W'(1);
      end
    end

    assign core_rd_dout[c*DATA_W +: DATA_W] = core_dout_q;
    assign host_rd_dout[c*DATA_W +: DATA_W] = host_dout_q;
    assign host_fill[c*FILL_W +: FILL_W]    = fill_q;
  end

endmodule
